sd_load_scheduler: RTL and testbench
====================================

SD_LOAD_SCHEDULER -- requirements
Module: sd_load_scheduler

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  TILE_BASE, 24'h000014, SD block address of the first tile-data block.
  TILE_BYTES, 1936, tile bytes to load (3872 nibbles).
  AUDIO_BASE, 24'h000018, SD block address of the first audio block.
  AUDIO_BLOCKS, 232, number of audio blocks before wrapping.
  FIFO_DEPTH, 8, 32-bit words held in the audio FIFO (power of 2).
REQ-002 Ports (name, direction, width, meaning):
  MasterCLK  in  1  sole clock; every register is rising-edge.
  Reset  in  1  asynchronous, active-low reset.
  Start  in  1  one-cycle pulse that begins the load sequence.
  SD_ReqValid  out  1  block read request.
  SD_ReqReady  in  1  SD reader accepts the request.
  SD_Address  out  24  block address, held stable while SD_ReqValid=1.
  SD_ByteValid  in  1  SD_ByteData is valid.
  SD_ByteData  in  8  byte from the SD reader.
  SD_ByteReady  out  1  scheduler can accept a byte this cycle.
  SD_BlockDone  in  1  pulse after the last byte (512th) of a block.
  SD_Error  in  1  pulse: current block transfer failed.
  TileWrEn  out  1  tile RAM byte write strobe.
  TileWrAddr  out  11  tile RAM byte address (the nibble pair).
  TileWrData  out  8  [7:4] is the even nibble, [3:0] the odd nibble.
  SampleReq  in  1  I2S pulse requesting the next sample.
  SampleData  out  32  current audio sample.
  Underrun  out  1  one-cycle pulse when SampleReq finds the FIFO empty.
  TilesLoaded  out  1  high once tile loading has completed.
  FifoLevel  out  4  FIFO occupancy in words.

Function
REQ-003 FSM states: IDLE, REQ_TILE, LOAD_TILE, REQ_AUDIO, STREAM_AUDIO.
REQ-004 IDLE: Start moves to REQ_TILE with SD_Address=TILE_BASE. Start in any other state is ignored.
REQ-005 In REQ_* states, SD_ReqValid=1. A cycle with SD_ReqValid & SD_ReqReady moves to the matching LOAD_TILE or STREAM_AUDIO state. SD_ReqValid=0 outside REQ_* states.
REQ-006 A byte is accepted only in a cycle with SD_ByteValid & SD_ByteReady. Bytes in any other cycle are ignored.
REQ-007 LOAD_TILE:
  - SD_ByteReady=1.
  - Each accepted byte with tile byte counter < TILE_BYTES produces TileWrEn=1 the next cycle, with TileWrAddr=counter and TileWrData=byte; the counter then increments.
  - Bytes at or beyond TILE_BYTES are dropped without a write.
REQ-008 SD_BlockDone in LOAD_TILE:
  - counter < TILE_BYTES: SD_Address+1, go to REQ_TILE.
  - otherwise: TilesLoaded<=1, SD_Address<=AUDIO_BASE, go to REQ_AUDIO.
  - With default parameters this takes 4 blocks; the last 112 bytes of block 4 are dropped.
REQ-009 STREAM_AUDIO byte packing:
  - Bytes are packed little-endian: the first byte goes to [7:0], the fourth to [31:24].
  - The fourth byte pushes the assembled word into the FIFO.
REQ-010 SD_ByteReady=0 in STREAM_AUDIO only when FIFO is full and 3 bytes are already held. It is registered, so the FIFO never overflows.
REQ-011 SD_BlockDone in STREAM_AUDIO:
  - SD_Address increments.
  - When SD_Address=AUDIO_BASE+AUDIO_BLOCKS-1, it wraps to AUDIO_BASE.
  - Next state is REQ_AUDIO.
  - Partial word bytes are kept across the block boundary.
REQ-012 SampleReq handling:
  - FIFO non-empty: the head word is popped and SampleData is updated the next cycle.
  - FIFO empty: SampleData<=0 and Underrun=1 for one cycle.
REQ-013 A push and a pop in the same cycle are both performed; FifoLevel is unchanged.
REQ-014 SD_Error in LOAD_TILE or STREAM_AUDIO returns to the matching REQ state with the same SD_Address.
  - Tile: the byte counter rewinds to the value it had at the start of that block.
  - Audio: held partial bytes are discarded; FIFO contents are kept.
  - SD_Error in any other state is ignored.
REQ-015 If SD_Error and SD_BlockDone occur in the same cycle, SD_Error wins.
REQ-016 Audio streaming continues indefinitely. Only Reset returns the FSM to IDLE.

Reset
REQ-017 Reset=0 asynchronously forces:
  - state IDLE and SD_Address=TILE_BASE;
  - all counters, FIFO pointers and FifoLevel to 0;
  - SD_ReqValid, TileWrEn, Underrun and TilesLoaded to 0;
  - SampleData and TileWrData to 0, and SD_ByteReady to 0.
REQ-018 Reset asserted mid-transfer abandons the transfer. After release, the block waits for Start.

Verification
REQ-019 Reset release, Start pulse, SD_ReqReady=1 -> SD_Address sequence 0x14, 0x15, 0x16, 0x17. TileWrAddr covers 0..1935, each exactly once. TilesLoaded rises after the 4th BlockDone. The next request is at 0x18.
REQ-020 SD_Error at byte 100 of tile block 2 -> re-request 0x15. Writes restart at TileWrAddr 512. There are no writes beyond 1935.
REQ-021 Audio bytes 01,02,03,04 then SampleReq -> SampleData=32'h04030201 one cycle later, and FifoLevel returns to 0.
REQ-022 With SampleReq held low, feed audio until FIFO is full plus 3 bytes -> SD_ByteReady=0 and FifoLevel=8. One SampleReq -> SD_ByteReady=1 again, with no word lost.
REQ-023 SampleReq with FIFO empty -> Underrun pulse, SampleData=0. Audio block at address 0x18+231 completes -> next SD_Address=0x18.
REQ-024 Reset asserted during STREAM_AUDIO -> all outputs at reset values immediately. A new Start re-requests 0x14.

Source files
------------

// File: rtl/sd_load_scheduler.sv
// Loads tile data from SD blocks into tile RAM, then streams audio blocks into a word FIFO drained by I2S.
// Tile writes and FIFO pushes appear one cycle after the accepted byte; SD_ByteReady drops only when a full FIFO meets a complete word.
module sd_load_scheduler #(
  parameter logic [23:0] TILE_BASE    = 24'h000014,
  parameter int          TILE_BYTES   = 1936,
  parameter logic [23:0] AUDIO_BASE   = 24'h000018,
  parameter int          AUDIO_BLOCKS = 232,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        MasterCLK,
  input  logic        Reset,
  input  logic        Start,
  output logic        SD_ReqValid,
  input  logic        SD_ReqReady,
  output logic [23:0] SD_Address,
  input  logic        SD_ByteValid,
  input  logic [7:0]  SD_ByteData,
  output logic        SD_ByteReady,
  input  logic        SD_BlockDone,
  input  logic        SD_Error,
  output logic        TileWrEn,
  output logic [10:0] TileWrAddr,
  output logic [7:0]  TileWrData,
  input  logic        SampleReq,
  output logic [31:0] SampleData,
  output logic        Underrun,
  output logic        TilesLoaded,
  output logic [3:0]  FifoLevel
);
  localparam int          PW         = $clog2(FIFO_DEPTH);
  localparam logic [11:0] TILE_END   = 12'(TILE_BYTES);
  localparam logic [23:0] AUDIO_LAST = AUDIO_BASE + 24'(AUDIO_BLOCKS - 1);
  localparam logic [3:0]  FIFO_FULL  = 4'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, REQ_TILE, LOAD_TILE, REQ_AUDIO, STREAM_AUDIO} state_t;

  state_t        state, nextState;
  logic [11:0]   tileCount, tileBlockStart, nextTileCount;
  logic [1:0]    heldCount, nextHeldCount;
  logic [23:0]   heldBytes;
  logic [PW-1:0] wrPtr, rdPtr;
  logic [3:0]    nextLevel;
  logic [31:0]   fifoMem [FIFO_DEPTH];
  logic          byteTake, tileWrite, audioTake, push, pop;

  always_comb begin
    byteTake      = SD_ByteValid & SD_ByteReady & ~SD_Error;
    tileWrite     = byteTake & (state == LOAD_TILE) & (tileCount < TILE_END);
    audioTake     = byteTake & (state == STREAM_AUDIO);
    push          = audioTake & (heldCount == 2'd3);
    pop           = SampleReq & (FifoLevel != 4'd0);
    nextTileCount = tileCount + {11'd0, tileWrite};
    nextHeldCount = heldCount + {1'b0, audioTake};
    nextLevel     = FifoLevel + {3'd0, push} - {3'd0, pop};
    nextState     = state;
    case (state)
      IDLE:         if (Start) nextState = REQ_TILE;
      REQ_TILE:     if (SD_ReqValid & SD_ReqReady) nextState = LOAD_TILE;
      LOAD_TILE:
        if (SD_Error) nextState = REQ_TILE;
        else if (SD_BlockDone) nextState = (nextTileCount < TILE_END) ? REQ_TILE : REQ_AUDIO;
      REQ_AUDIO:    if (SD_ReqValid & SD_ReqReady) nextState = STREAM_AUDIO;
      STREAM_AUDIO: if (SD_Error | SD_BlockDone) nextState = REQ_AUDIO;
      default:      nextState = IDLE;
    endcase
    // A failed audio block is re-read from its start, so its partial word is worthless
    if ((state == STREAM_AUDIO) & SD_Error) nextHeldCount = 2'd0;
  end

  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) begin
      state          <= IDLE;
      SD_Address     <= TILE_BASE;
      SD_ReqValid    <= 1'b0;
      SD_ByteReady   <= 1'b0;
      TileWrEn       <= 1'b0;
      TileWrAddr     <= 11'd0;
      TileWrData     <= 8'd0;
      SampleData     <= 32'd0;
      Underrun       <= 1'b0;
      TilesLoaded    <= 1'b0;
      FifoLevel      <= 4'd0;
      tileCount      <= 12'd0;
      tileBlockStart <= 12'd0;
      heldCount      <= 2'd0;
      heldBytes      <= 24'd0;
      wrPtr          <= '0;
      rdPtr          <= '0;
    end else begin
      state        <= nextState;
      SD_ReqValid  <= (nextState == REQ_TILE) | (nextState == REQ_AUDIO);
      // Ready looks one cycle ahead: a fourth byte is refused only if its word would have nowhere to go
      SD_ByteReady <= (nextState == LOAD_TILE) |
                      ((nextState == STREAM_AUDIO) & ~((nextLevel == FIFO_FULL) & (nextHeldCount == 2'd3)));
      TileWrEn     <= tileWrite;
      if (tileWrite) begin
        TileWrAddr <= tileCount[10:0];
        TileWrData <= SD_ByteData;
      end
      tileCount <= nextTileCount;
      heldCount <= nextHeldCount;
      if (audioTake) begin
        case (heldCount)
          2'd0:    heldBytes[7:0]   <= SD_ByteData;
          2'd1:    heldBytes[15:8]  <= SD_ByteData;
          2'd2:    heldBytes[23:16] <= SD_ByteData;
          default: ;
        endcase
      end
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      FifoLevel <= nextLevel;
      Underrun  <= SampleReq & (FifoLevel == 4'd0);
      if (SampleReq) SampleData <= pop ? fifoMem[rdPtr] : 32'd0;
      case (state)
        IDLE: if (Start) SD_Address <= TILE_BASE;
        LOAD_TILE:
          if (SD_Error) tileCount <= tileBlockStart;
          else if (SD_BlockDone) begin
            if (nextTileCount < TILE_END) begin
              SD_Address     <= SD_Address + 24'd1;
              tileBlockStart <= nextTileCount;
            end else begin
              TilesLoaded <= 1'b1;
              SD_Address  <= AUDIO_BASE;
            end
          end
        STREAM_AUDIO:
          if (!SD_Error && SD_BlockDone)
            SD_Address <= (SD_Address == AUDIO_LAST) ? AUDIO_BASE : SD_Address + 24'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge MasterCLK) begin
    if (push) fifoMem[wrPtr] <= {SD_ByteData, heldBytes};
  end

endmodule

// File: tb/tb_sd_load_scheduler.sv
// Directed sequence with random payloads; tile and audio expectations come from a queue/array model of the load rules.
module tb_sd_load_scheduler;
  logic        MasterCLK = 1'b0, Reset = 1'b0, Start = 1'b0, SD_ReqReady = 1'b1;
  logic        SD_ByteValid = 1'b0, SD_BlockDone = 1'b0, SD_Error = 1'b0, SampleReq = 1'b0;
  logic [7:0]  SD_ByteData = 8'd0;
  logic        SD_ReqValid, SD_ByteReady, TileWrEn, Underrun, TilesLoaded;
  logic [23:0] SD_Address;
  logic [10:0] TileWrAddr;
  logic [7:0]  TileWrData;
  logic [31:0] SampleData;
  logic [3:0]  FifoLevel;

  sd_load_scheduler dut (
    .MasterCLK(MasterCLK), .Reset(Reset), .Start(Start),
    .SD_ReqValid(SD_ReqValid), .SD_ReqReady(SD_ReqReady), .SD_Address(SD_Address),
    .SD_ByteValid(SD_ByteValid), .SD_ByteData(SD_ByteData), .SD_ByteReady(SD_ByteReady),
    .SD_BlockDone(SD_BlockDone), .SD_Error(SD_Error),
    .TileWrEn(TileWrEn), .TileWrAddr(TileWrAddr), .TileWrData(TileWrData),
    .SampleReq(SampleReq), .SampleData(SampleData), .Underrun(Underrun),
    .TilesLoaded(TilesLoaded), .FifoLevel(FifoLevel)
  );

  always #5 MasterCLK = ~MasterCLK;

  int          checks = 0, passes = 0;
  logic [7:0]  tileExp [1936];
  logic [18:0] wrLog [$];
  logic [31:0] wordQ [$];
  logic [7:0]  partial [$];
  bit          tileMode = 1'b1;
  int          tileIdx = 0, audioBlk = 0, errMark = -1;

  always @(negedge MasterCLK) if (TileWrEn) wrLog.push_back({TileWrAddr, TileWrData});

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic feedByte(input logic [7:0] b);
    int tries = 0;
    @(negedge MasterCLK);
    SD_ByteValid = 1'b1;
    SD_ByteData  = b;
    while (!SD_ByteReady) begin
      tries++;
      if (tries > 50) begin
        check("byte_ready_timeout", {31'd0, SD_ByteReady}, 32'd1);
        SD_ByteValid = 1'b0;
        return;
      end
      @(negedge MasterCLK);
    end
    if (tileMode) begin
      if (tileIdx < 1936) tileExp[tileIdx] = b;
      tileIdx++;
    end else begin
      partial.push_back(b);
      if (partial.size() == 4) begin
        wordQ.push_back({partial[3], partial[2], partial[1], partial[0]});
        partial.delete();
      end
    end
  endtask

  task automatic blockDone();
    @(negedge MasterCLK);
    SD_ByteValid = 1'b0;
    SD_BlockDone = 1'b1;
    @(negedge MasterCLK);
    SD_BlockDone = 1'b0;
  endtask

  task automatic errorPulse();
    @(negedge MasterCLK);
    SD_ByteValid = 1'b0;
    SD_Error     = 1'b1;
    @(negedge MasterCLK);
    SD_Error     = 1'b0;
  endtask

  task automatic waitReq(input string tag, input logic [23:0] expAddr);
    int n = 0;
    while (!SD_ReqValid && n < 50) begin
      @(negedge MasterCLK);
      n++;
    end
    check(tag, {7'd0, SD_ReqValid, SD_Address}, {7'd0, 1'b1, expAddr});
  endtask

  task automatic popCheck(input string tag);
    logic [31:0] exp;
    bit          under;
    @(negedge MasterCLK);
    SD_ByteValid = 1'b0;
    SampleReq    = 1'b1;
    under = (wordQ.size() == 0);
    exp   = under ? 32'd0 : wordQ.pop_front();
    @(negedge MasterCLK);
    SampleReq = 1'b0;
    check({tag, "_data"}, SampleData, exp);
    check({tag, "_underrun"}, {31'd0, Underrun}, {31'd0, under});
    check({tag, "_level"}, {28'd0, FifoLevel}, wordQ.size());
  endtask

  task automatic loadTiles(input int errBlk, input int errAt);
    tileMode = 1'b1;
    for (int b = 0; b < 4; b++) begin
      waitReq("tile_req", 24'(32'h14 + b));
      if (b == errBlk) begin
        tileIdx = b * 512;
        for (int k = 0; k < errAt; k++) feedByte(8'($urandom));
        errorPulse();
        errMark = wrLog.size();
        waitReq("tile_rereq", 24'(32'h14 + b));
      end
      tileIdx = b * 512;
      for (int k = 0; k < 512; k++) feedByte(8'($urandom));
      if (b == 3) check("tiles_loaded_before", {31'd0, TilesLoaded}, 32'd0);
      blockDone();
    end
    check("tiles_loaded_after", {31'd0, TilesLoaded}, 32'd1);
    waitReq("first_audio_req", 24'h18);
    tileMode = 1'b0;
  endtask

  task automatic analyzeTiles(input int errBlk, input int errAt);
    int         cnt [2048];
    logic [7:0] last [2048];
    int         badCnt = 0, badData = 0, beyond = 0;
    foreach (cnt[i]) cnt[i] = 0;
    foreach (wrLog[i]) begin
      cnt[wrLog[i][18:8]]++;
      last[wrLog[i][18:8]] = wrLog[i][7:0];
    end
    for (int a = 0; a < 2048; a++) begin
      int expCnt;
      expCnt = (a < 1936) ? 1 + ((a >= errBlk * 512 && a < errBlk * 512 + errAt) ? 1 : 0) : 0;
      if (cnt[a] != expCnt) badCnt++;
      if (a < 1936 && cnt[a] > 0 && last[a] !== tileExp[a]) badData++;
      if (a >= 1936 && cnt[a] > 0) beyond++;
    end
    check("tile_write_counts", badCnt, 0);
    check("tile_write_data", badData, 0);
    check("tile_writes_beyond_end", beyond, 0);
  endtask

  initial begin
    logic [31:0] expWord;
    logic [7:0]  stallByte;
    int          n;

    repeat (2) @(negedge MasterCLK);
    check("rst_req_valid", {31'd0, SD_ReqValid}, 32'd0);
    check("rst_address", {8'd0, SD_Address}, 32'h14);
    check("rst_byte_ready", {31'd0, SD_ByteReady}, 32'd0);
    check("rst_tile_wr", {31'd0, TileWrEn}, 32'd0);
    check("rst_tiles_loaded", {31'd0, TilesLoaded}, 32'd0);
    check("rst_sample", SampleData, 32'd0);
    check("rst_level", {28'd0, FifoLevel}, 32'd0);
    check("rst_underrun", {31'd0, Underrun}, 32'd0);
    Reset = 1'b1;
    repeat (3) @(negedge MasterCLK);
    check("idle_waits_start", {31'd0, SD_ReqValid}, 32'd0);

    Start = 1'b1;
    @(negedge MasterCLK);
    Start = 1'b0;
    loadTiles(-1, 0);
    analyzeTiles(-1, 0);

    popCheck("underrun");
    @(negedge MasterCLK);
    check("underrun_one_cycle", {31'd0, Underrun}, 32'd0);

    feedByte(8'h01); feedByte(8'h02); feedByte(8'h03); feedByte(8'h04);
    @(negedge MasterCLK);
    SD_ByteValid = 1'b0;
    check("fixed_level", {28'd0, FifoLevel}, 32'd1);
    popCheck("fixed_word");
    check("fixed_word_value", SampleData, 32'h04030201);

    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(12, 4);
      for (int k = 0; k < n; k++) feedByte(8'($urandom));
      for (int p = 0; p < 3; p++) popCheck("rand_pop");
    end

    // partial words survive a block boundary
    feedByte(8'($urandom)); feedByte(8'($urandom));
    blockDone();
    audioBlk++;
    waitReq("audio_next", 24'(32'h18 + audioBlk));
    for (int k = 0; k < 6; k++) feedByte(8'($urandom));
    while (wordQ.size() != 0) popCheck("boundary_pop");

    for (int k = 0; k < 6; k++) feedByte(8'($urandom));
    errorPulse();
    partial.delete();
    waitReq("audio_rereq", 24'(32'h18 + audioBlk));
    check("audio_err_keeps_fifo", {28'd0, FifoLevel}, wordQ.size());
    for (int k = 0; k < 4; k++) feedByte(8'($urandom));
    while (wordQ.size() != 0) popCheck("err_pop");

    while (!(wordQ.size() == 8 && partial.size() == 3)) feedByte(8'($urandom));
    stallByte = 8'($urandom);
    @(negedge MasterCLK);
    SD_ByteData = stallByte;
    check("full_ready_low", {31'd0, SD_ByteReady}, 32'd0);
    check("full_level", {28'd0, FifoLevel}, 32'd8);
    repeat (3) @(negedge MasterCLK);
    check("full_still_stalled", {27'd0, SD_ByteReady, FifoLevel}, {27'd0, 1'b0, 4'd8});
    SampleReq = 1'b1;
    expWord = wordQ.pop_front();
    @(negedge MasterCLK);
    SampleReq = 1'b0;
    check("full_pop_data", SampleData, expWord);
    check("full_ready_back", {31'd0, SD_ByteReady}, 32'd1);
    partial.push_back(stallByte);
    wordQ.push_back({partial[3], partial[2], partial[1], partial[0]});
    partial.delete();
    @(negedge MasterCLK);
    SD_ByteValid = 1'b0;
    check("full_level_after", {28'd0, FifoLevel}, 32'd8);
    while (wordQ.size() != 0) popCheck("drain_full");

    while (audioBlk < 233) begin
      blockDone();
      audioBlk++;
      if (audioBlk % 232 == 0) waitReq("audio_wrap", 24'h18);
      else waitReq("audio_addr", 24'(32'h18 + audioBlk % 232));
    end

    for (int k = 0; k < 6; k++) feedByte(8'($urandom));
    popCheck("pre_reset_pop");
    for (int k = 0; k < 6; k++) feedByte(8'($urandom));
    #2 Reset = 1'b0;
    #1;
    check("async_rst_req", {31'd0, SD_ReqValid}, 32'd0);
    check("async_rst_ready", {31'd0, SD_ByteReady}, 32'd0);
    check("async_rst_level", {28'd0, FifoLevel}, 32'd0);
    check("async_rst_sample", SampleData, 32'd0);
    check("async_rst_loaded", {31'd0, TilesLoaded}, 32'd0);
    check("async_rst_address", {8'd0, SD_Address}, 32'h14);
    SD_ByteValid = 1'b0;
    wordQ.delete();
    partial.delete();
    wrLog.delete();
    repeat (2) @(negedge MasterCLK);
    Reset = 1'b1;
    repeat (3) @(negedge MasterCLK);
    check("post_rst_waits_start", {31'd0, SD_ReqValid}, 32'd0);

    Start = 1'b1;
    @(negedge MasterCLK);
    Start = 1'b0;
    loadTiles(1, 100);
    analyzeTiles(1, 100);
    check("err_restart_addr", (errMark >= 0 && errMark < wrLog.size()) ? {21'd0, wrLog[errMark][18:8]} : 32'hFFFF_FFFF, 32'd512);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
